// File: rtl/dmem_pkg.sv
// Shared encodings and the load-lane helper for the banked data memory.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_UNMAPPED = 2'b01;
    localparam logic [1:0] ERR_MISALIGN = 2'b10;
    localparam logic [1:0] ERR_SIZE     = 2'b11;

    typedef enum logic [0:0] {IDLE, RESP} state_e;

    // Big-endian lane pick: offset 0 is the most significant byte.
    function automatic logic [31:0] lane_extend(input logic [31:0] word, input logic [1:0] size,
                                                input logic [1:0] off, input logic sgn);
        logic [31:0] res;
        logic [7:0]  b;
        logic [15:0] h;
        res = word;
        case (off)
            2'd0:    b = word[31:24];
            2'd1:    b = word[23:16];
            2'd2:    b = word[15:8];
            default: b = word[7:0];
        endcase
        h = off[1] ? word[15:0] : word[31:16];
        case (size)
            SZ_BYTE: res = {{24{sgn & b[7]}}, b};
            SZ_HALF: res = {{16{sgn & h[15]}}, h};
            default: res = word;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/banked_data_memory_if.sv
// Request/response bus between a datapath and the banked data memory.
interface banked_data_memory_if;

    logic        req_valid;
    logic        req_ready;
    logic [31:0] addr_in;
    logic        we_in;
    logic [1:0]  size_in;
    logic        signed_in;
    logic [31:0] writedata_in;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] readdata_out;
    logic        resp_err;
    logic [1:0]  err_code;

    modport master (
        output req_valid, addr_in, we_in, size_in, signed_in, writedata_in, resp_ready,
        input  req_ready, resp_valid, readdata_out, resp_err, err_code
    );

    modport slave (
        input  req_valid, addr_in, we_in, size_in, signed_in, writedata_in, resp_ready,
        output req_ready, resp_valid, readdata_out, resp_err, err_code
    );

endinterface

// File: rtl/banked_data_memory_seg_ram.sv
// Single-port word RAM with byte enables and a registered read port.
module seg_ram #(
    parameter int unsigned AW = 10
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic          we_i,
    input  logic [3:0]    be_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [2**AW];
    logic [31:0] rdata_q;

    // Stores leave the read register untouched so a stalled response stays stable.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int b = 0; b < 4; b++) begin
                    if (be_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end else begin
                rdata_q <= mem[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/banked_data_memory.sv
// Banked data memory: segment decode, error check, handshake FSM and load response path.
module banked_data_memory
    import dmem_pkg::*;
#(
    parameter int unsigned NUM_SEGS = 2,
    parameter logic [15:0] SEG_TAG0 = 16'h1000,
    parameter logic [15:0] SEG_TAG1 = 16'h7fff,
    parameter logic [15:0] SEG_TAG2 = 16'h0000,
    parameter logic [15:0] SEG_TAG3 = 16'h0000,
    parameter int unsigned SEG_AW   = 10
) (
    input logic                 clock,
    input logic                 reset,
    banked_data_memory_if.slave bus
);

    localparam logic [3:0][15:0] SEG_TAGS = {SEG_TAG3, SEG_TAG2, SEG_TAG1, SEG_TAG0};

    state_e            state_q, state_d;
    logic              accept;
    logic              seg_hit;
    logic [1:0]        seg_sel;
    logic [1:0]        req_err;
    logic [3:0]        be;
    logic [31:0]       wdata_rep;
    logic [SEG_AW-1:0] word_idx;
    logic [31:0]       seg_rdata [4];

    logic [1:0] size_q, size_d;
    logic [1:0] off_q, off_d;
    logic [1:0] err_q, err_d;
    logic [1:0] seg_q, seg_d;
    logic       signed_q, signed_d;
    logic       we_q, we_d;

    // Offset bits above the word index are deliberately ignored (segment wraps).
    logic unused_addr;
    assign unused_addr = ^(bus.addr_in[15:0] >> (SEG_AW + 2));

    assign accept   = bus.req_valid && bus.req_ready;
    assign word_idx = bus.addr_in[SEG_AW+1:2];

    // Descending scan so the lowest matching index wins.
    always_comb begin
        seg_hit = 1'b0;
        seg_sel = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if ((i < int'(NUM_SEGS)) && (bus.addr_in[31:16] == SEG_TAGS[2'(i)])) begin
                seg_hit = 1'b1;
                seg_sel = 2'(i);
            end
        end
    end

    always_comb begin
        req_err = ERR_NONE;
        if (bus.size_in == 2'b10) begin
            req_err = ERR_SIZE;
        end else if (((bus.size_in == SZ_HALF) && bus.addr_in[0]) ||
                     ((bus.size_in == SZ_WORD) && (bus.addr_in[1:0] != 2'b00))) begin
            req_err = ERR_MISALIGN;
        end else if (!seg_hit) begin
            req_err = ERR_UNMAPPED;
        end
    end

    always_comb begin
        be        = 4'b0000;
        wdata_rep = bus.writedata_in;
        case (bus.size_in)
            SZ_BYTE: begin
                be        = 4'b1000 >> bus.addr_in[1:0];
                wdata_rep = {4{bus.writedata_in[7:0]}};
            end
            SZ_HALF: begin
                be        = bus.addr_in[1] ? 4'b0011 : 4'b1100;
                wdata_rep = {2{bus.writedata_in[15:0]}};
            end
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
    end

    for (genvar g = 0; g < 4; g++) begin : g_seg
        if (g < NUM_SEGS) begin : g_ram
            logic en_seg;
            assign en_seg = accept && (req_err == ERR_NONE) && (seg_sel == 2'(g));
            seg_ram #(
                .AW(SEG_AW)
            ) u_ram (
                .clk_i  (clock),
                .en_i   (en_seg),
                .we_i   (bus.we_in),
                .be_i   (be),
                .addr_i (word_idx),
                .wdata_i(wdata_rep),
                .rdata_o(seg_rdata[g])
            );
        end else begin : g_none
            assign seg_rdata[g] = 32'h0;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept) state_d = RESP;
            RESP:    if (bus.resp_ready && !accept) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.req_ready    = (state_q == IDLE) || ((state_q == RESP) && bus.resp_ready);
        bus.resp_valid   = (state_q == RESP);
        bus.resp_err     = (state_q == RESP) && (err_q != ERR_NONE);
        bus.err_code     = (state_q == RESP) ? err_q : ERR_NONE;
        bus.readdata_out = 32'h0;
        if ((state_q == RESP) && !we_q && (err_q == ERR_NONE)) begin
            bus.readdata_out = lane_extend(seg_rdata[seg_q], size_q, off_q, signed_q);
        end
    end

    always_comb begin
        size_d   = size_q;
        off_d    = off_q;
        err_d    = err_q;
        seg_d    = seg_q;
        signed_d = signed_q;
        we_d     = we_q;
        if (accept) begin
            size_d   = bus.size_in;
            off_d    = bus.addr_in[1:0];
            err_d    = req_err;
            seg_d    = seg_sel;
            signed_d = bus.signed_in;
            we_d     = bus.we_in;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            size_q   <= SZ_BYTE;
            off_q    <= 2'd0;
            err_q    <= ERR_NONE;
            seg_q    <= 2'd0;
            signed_q <= 1'b0;
            we_q     <= 1'b0;
        end else begin
            size_q   <= size_d;
            off_q    <= off_d;
            err_q    <= err_d;
            seg_q    <= seg_d;
            signed_q <= signed_d;
            we_q     <= we_d;
        end
    end

endmodule

// File: tb/tb_banked_data_memory.sv
// Directed scoreboard bench for banked_data_memory with default two-segment map.
module tb_banked_data_memory;
    import dmem_pkg::*;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    banked_data_memory_if bus();

    banked_data_memory dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        err;
        logic [1:0]  code;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   resp_cnt = 0;
    int   cyc = 0;
    int   waits_total = 0;
    int   r0;

    always @(posedge clock) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    always @(negedge clock) begin : mon
        exp_t e;
        if (reset && bus.resp_valid && bus.resp_ready) begin
            resp_cnt++;
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $error("FAIL unexpected_resp: observed response %0d expected none", resp_cnt);
            end else begin
                e = sb.pop_front();
                check($sformatf("resp%0d.data", resp_cnt), bus.readdata_out, e.data);
                check($sformatf("resp%0d.err", resp_cnt), 32'(bus.resp_err), 32'(e.err));
                check($sformatf("resp%0d.code", resp_cnt), 32'(bus.err_code), 32'(e.code));
                if (e.cyc >= 0) check($sformatf("resp%0d.latency", resp_cnt), 32'(cyc - e.cyc), 32'd1);
            end
        end
    end

    task automatic issue(input logic [31:0] addr, input logic we, input logic [1:0] size,
                         input logic sgn, input logic [31:0] wd, input logic [31:0] ed,
                         input logic [1:0] ec, input bit push);
        int waits;
        @(negedge clock);
        bus.req_valid    = 1'b1;
        bus.addr_in      = addr;
        bus.we_in        = we;
        bus.size_in      = size;
        bus.signed_in    = sgn;
        bus.writedata_in = wd;
        waits = 0;
        while (!bus.req_ready && waits < 20) begin
            @(negedge clock);
            waits++;
        end
        waits_total += waits;
        if (!bus.req_ready) begin
            tests++;
            fails++;
            $error("FAIL accept_timeout: observed req_ready 0 expected 1 at addr %h", addr);
        end else if (push) begin
            sb.push_back('{data: ed, err: (ec != ERR_NONE), code: ec, cyc: cyc});
        end
        @(posedge clock);
    endtask

    task automatic st(input logic [31:0] addr, input logic [1:0] size, input logic [31:0] wd,
                      input logic [1:0] ec);
        issue(addr, 1'b1, size, 1'b0, wd, 32'h0, ec, 1'b1);
    endtask

    task automatic ld(input logic [31:0] addr, input logic [1:0] size, input logic sgn,
                      input logic [31:0] ed, input logic [1:0] ec);
        issue(addr, 1'b0, size, sgn, 32'h0, ed, ec, 1'b1);
    endtask

    task automatic idle();
        @(negedge clock);
        bus.req_valid = 1'b0;
    endtask

    initial begin
        bus.req_valid    = 1'b0;
        bus.addr_in      = 32'h0;
        bus.we_in        = 1'b0;
        bus.size_in      = SZ_WORD;
        bus.signed_in    = 1'b0;
        bus.writedata_in = 32'h0;
        bus.resp_ready   = 1'b1;

        repeat (2) @(negedge clock);
        check("rst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("rst.readdata", bus.readdata_out, 32'h0);
        check("rst.resp_err", 32'(bus.resp_err), 32'd0);
        check("rst.err_code", 32'(bus.err_code), 32'd0);
        reset = 1'b1;
        #1;
        check("rst.req_ready", 32'(bus.req_ready), 32'd1);

        st(32'h1000_0010, SZ_WORD, 32'hDEAD_BEEF, ERR_NONE);
        ld(32'h1000_0010, SZ_WORD, 1'b0, 32'hDEAD_BEEF, ERR_NONE);

        st(32'h1000_0000, SZ_WORD, 32'h0, ERR_NONE);
        st(32'h1000_0001, SZ_BYTE, 32'h0000_00AB, ERR_NONE);
        ld(32'h1000_0000, SZ_WORD, 1'b0, 32'h00AB_0000, ERR_NONE);
        st(32'h1000_0003, SZ_BYTE, 32'h1234_5680, ERR_NONE);
        ld(32'h1000_0003, SZ_BYTE, 1'b1, 32'hFFFF_FF80, ERR_NONE);
        ld(32'h1000_0003, SZ_BYTE, 1'b0, 32'h0000_0080, ERR_NONE);
        ld(32'h1000_0000, SZ_HALF, 1'b0, 32'h0000_00AB, ERR_NONE);
        ld(32'h1000_0002, SZ_HALF, 1'b1, 32'h0000_0080, ERR_NONE);

        st(32'h7fff_0000, SZ_WORD, 32'h1122_3344, ERR_NONE);
        ld(32'h7fff_0003, SZ_BYTE, 1'b0, 32'h0000_0044, ERR_NONE);
        ld(32'h7fff_0001, SZ_HALF, 1'b0, 32'h0, ERR_MISALIGN);
        st(32'h7fff_0001, SZ_HALF, 32'h0000_FFFF, ERR_MISALIGN);
        st(32'h7fff_0000, 2'b10, 32'h0, ERR_SIZE);
        ld(32'h7fff_0000, SZ_WORD, 1'b0, 32'h1122_3344, ERR_NONE);
        ld(32'h7fff_0000, 2'b10, 1'b0, 32'h0, ERR_SIZE);
        ld(32'h2000_0001, 2'b10, 1'b0, 32'h0, ERR_SIZE);
        ld(32'h1000_0002, SZ_WORD, 1'b0, 32'h0, ERR_MISALIGN);
        ld(32'h2000_0000, SZ_WORD, 1'b0, 32'h0, ERR_UNMAPPED);
        ld(32'h2000_0001, SZ_WORD, 1'b0, 32'h0, ERR_MISALIGN);
        ld(32'h2000_0003, SZ_BYTE, 1'b0, 32'h0, ERR_UNMAPPED);

        // 0x1000fff0 and 0x10000ff0 share word index 0x3FC.
        st(32'h1000_fff0, SZ_WORD, 32'hCAFE_F00D, ERR_NONE);
        ld(32'h1000_0ff0, SZ_WORD, 1'b0, 32'hCAFE_F00D, ERR_NONE);

        for (int i = 0; i < 8; i++) begin
            st(32'h7fff_0100 + 32'(4 * i), SZ_WORD, 32'hA500_0000 + 32'(i * 32'h0101), ERR_NONE);
        end
        idle();
        repeat (2) @(posedge clock);
        #1;
        r0 = resp_cnt;
        waits_total = 0;
        for (int i = 0; i < 8; i++) begin
            ld(32'h7fff_0100 + 32'(4 * i), SZ_WORD, 1'b0, 32'hA500_0000 + 32'(i * 32'h0101),
               ERR_NONE);
        end
        idle();
        repeat (2) @(posedge clock);
        #1;
        check("b2b.waits", 32'(waits_total), 32'd0);
        check("b2b.resp_count", 32'(resp_cnt - r0), 32'd8);

        st(32'h7fff_0200, SZ_WORD, 32'h600D_F00D, ERR_NONE);
        idle();
        @(negedge clock);
        bus.resp_ready = 1'b0;
        issue(32'h7fff_0200, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, ERR_NONE, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            bus.req_valid = 1'b0;
            check($sformatf("stall%0d.resp_valid", k), 32'(bus.resp_valid), 32'd1);
            check($sformatf("stall%0d.readdata", k), bus.readdata_out, 32'h600D_F00D);
            check($sformatf("stall%0d.req_ready", k), 32'(bus.req_ready), 32'd0);
        end
        @(posedge clock);
        #1;
        sb.push_back('{data: 32'h600D_F00D, err: 1'b0, code: ERR_NONE, cyc: -1});
        bus.resp_ready = 1'b1;
        repeat (2) @(posedge clock);

        st(32'h1000_0040, SZ_WORD, 32'h5A5A_1234, ERR_NONE);
        idle();
        @(negedge clock);
        bus.resp_ready = 1'b0;
        issue(32'h1000_0040, 1'b0, SZ_WORD, 1'b0, 32'h0, 32'h0, ERR_NONE, 1'b0);
        #2;
        check("prerst.resp_valid", 32'(bus.resp_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("midrst.resp_valid", 32'(bus.resp_valid), 32'd0);
        check("midrst.readdata", bus.readdata_out, 32'h0);
        check("midrst.err_code", 32'(bus.err_code), 32'd0);
        @(negedge clock);
        bus.req_valid  = 1'b0;
        bus.resp_ready = 1'b1;
        reset = 1'b1;
        #1;
        check("postrst.req_ready", 32'(bus.req_ready), 32'd1);
        ld(32'h1000_0040, SZ_WORD, 1'b0, 32'h5A5A_1234, ERR_NONE);
        ld(32'h1000_0010, SZ_WORD, 1'b0, 32'hDEAD_BEEF, ERR_NONE);
        idle();

        for (int t = 0; t < 10 && sb.size() != 0; t++) @(posedge clock);
        #1;
        check("sb.drained", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
